// File: rtl/param_countdown_timer.sv
// rtl/param_countdown_timer.sv - parametrised 1 Hz / 2 Hz strobe generator with loadable seconds countdown
//
// Purpose:
//   Free-running 1 Hz and 2 Hz one-cycle strobes derived from CLK_HZ,
//   plus a seconds countdown (IDLE -> RUN -> DONE) armed by start_timer.
//   Optional macro TIMER_PAUSE_EN adds a pause input that freezes the
//   prescalers and the countdown while in RUN.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous, active-high; clears all state
//   start_timer    in   level: 1 = arm/run, 0 = abort/release
//   pause          in   (TIMER_PAUSE_EN only) freeze countdown while in RUN
//   value          in   countdown length in seconds, sampled on load only
//   one_hz_enable  out  one-cycle strobe every CLK_HZ cycles
//   two_hz_enable  out  one-cycle strobe every CLK_HZ/2 cycles
//   expired        out  countdown finished; held until start_timer drops
//   busy           out  high while counting (RUN)
//   remaining      out  seconds left (0 when not running)
module param_countdown_timer #(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned COUNT_W       = 4,
  parameter bit          SYNC_ON_START = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_timer,
`ifdef TIMER_PAUSE_EN
  input  logic               pause,
`endif
  input  logic [COUNT_W-1:0] value,
  output logic               one_hz_enable,
  output logic               two_hz_enable,
  output logic               expired,
  output logic               busy,
  output logic [COUNT_W-1:0] remaining
);

  localparam int unsigned PRE_W = $clog2(CLK_HZ);
  localparam logic [PRE_W-1:0] ONE_MAX = PRE_W'(CLK_HZ - 1);
  localparam logic [PRE_W-1:0] TWO_MAX = PRE_W'(CLK_HZ / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [COUNT_W-1:0] remaining_next;
  logic [PRE_W-1:0]   one_cnt;
  logic [PRE_W-1:0]   two_cnt;
  logic               one_q;
  logic               two_q;
  logic               load;
  logic               freeze;
  logic               tick;

`ifdef TIMER_PAUSE_EN
  // Pause only has an effect while counting down.
  assign freeze = pause & (state == ST_RUN);
`else
  assign freeze = 1'b0;
`endif

  // Strobe registers are held (not cleared) during a freeze so that a tick
  // registered just before the pause is consumed once the pause lifts; the
  // visible strobes are masked meanwhile.
  assign one_hz_enable = one_q & ~freeze;
  assign two_hz_enable = two_q & ~freeze;
  assign tick          = one_hz_enable;

  assign busy    = (state == ST_RUN);
  assign expired = (state == ST_DONE);

  // Prescalers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      one_cnt <= '0;
      two_cnt <= '0;
      one_q   <= 1'b0;
      two_q   <= 1'b0;
    end else if (SYNC_ON_START && load) begin
      // Restart both seconds so the first countdown second is a full one.
      one_cnt <= '0;
      two_cnt <= '0;
      one_q   <= 1'b0;
      two_q   <= 1'b0;
    end else if (!freeze) begin
      one_cnt <= (one_cnt == ONE_MAX) ? '0 : one_cnt + 1'b1;
      two_cnt <= (two_cnt == TWO_MAX) ? '0 : two_cnt + 1'b1;
      one_q   <= (one_cnt == ONE_MAX);
      two_q   <= (two_cnt == TWO_MAX);
    end
  end

  // State and count register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
    end
  end

  // Next-state / next-count logic
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    load           = 1'b0;
    case (state)
      ST_IDLE: begin
        remaining_next = '0;
        if (start_timer) begin
          load           = 1'b1;
          // A zero request still runs for one full second.
          remaining_next = (value == '0) ? COUNT_W'(1) : value;
          state_next     = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort takes priority over a coincident tick.
        if (!start_timer) begin
          remaining_next = '0;
          state_next     = ST_IDLE;
        end else if (tick) begin
          // <= 1 rather than == 1 so the count can never wrap below zero.
          if (remaining <= COUNT_W'(1)) begin
            remaining_next = '0;
            state_next     = ST_DONE;
          end else begin
            remaining_next = remaining - 1'b1;
          end
        end
      end
      ST_DONE: begin
        remaining_next = '0;
        if (!start_timer) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        remaining_next = '0;
        state_next     = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_param_countdown_timer.sv
// tb/tb_param_countdown_timer.sv - directed self-checking bench for param_countdown_timer
module tb_param_countdown_timer;

  localparam int CLK_HZ  = 8;
  localparam int COUNT_W = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic               start_timer;
`ifdef TIMER_PAUSE_EN
  logic               pause;
`endif
  logic [COUNT_W-1:0] value;
  logic               one_hz_enable;
  logic               two_hz_enable;
  logic               expired;
  logic               busy;
  logic [COUNT_W-1:0] remaining;

  int tests_run    = 0;
  int tests_failed = 0;

  param_countdown_timer #(
    .CLK_HZ        (CLK_HZ),
    .COUNT_W       (COUNT_W),
    .SYNC_ON_START (1'b1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_timer   (start_timer),
`ifdef TIMER_PAUSE_EN
    .pause         (pause),
`endif
    .value         (value),
    .one_hz_enable (one_hz_enable),
    .two_hz_enable (two_hz_enable),
    .expired       (expired),
    .busy          (busy),
    .remaining     (remaining)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    start_timer = 1'b0;
    value       = '0;
`ifdef TIMER_PAUSE_EN
    pause       = 1'b0;
`endif
    tick();
    tick();
    tests_run++;
    if (one_hz_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_one_hz: got %b, expected 0", one_hz_enable); end
    tests_run++;
    if (two_hz_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_two_hz: got %b, expected 0", two_hz_enable); end
    tests_run++;
    if (expired !== 1'b0) begin tests_failed++; $display("FAIL reset_expired: got %b, expected 0", expired); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    tests_run++;
    if (remaining !== 4'd0) begin tests_failed++; $display("FAIL reset_remaining: got %0d, expected 0", remaining); end
    reset = 1'b0;
  endtask

  // Edge k after reset release: 1 Hz strobe on multiples of 8, 2 Hz on multiples of 4.
  task automatic test_strobes();
    for (int k = 1; k <= 24; k++) begin
      tick();
      tests_run++;
      if (one_hz_enable !== (k % 8 == 0)) begin tests_failed++; $display("FAIL strobe_one_hz k=%0d: got %b, expected %b", k, one_hz_enable, (k % 8 == 0)); end
      tests_run++;
      if (two_hz_enable !== (k % 4 == 0)) begin tests_failed++; $display("FAIL strobe_two_hz k=%0d: got %b, expected %b", k, two_hz_enable, (k % 4 == 0)); end
    end
  endtask

  // Load v on edge L; expiry expected at L + eff*8 + 1, then hold start for 20 more edges.
  task automatic test_countdown(input int v);
    int               eff;
    logic             exp_expired;
    logic [COUNT_W-1:0] exp_rem;
    eff         = (v == 0) ? 1 : v;
    value       = COUNT_W'(v);
    start_timer = 1'b1;
    tick();
    value = 4'hF;
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL load_busy v=%0d: got %b, expected 1", v, busy); end
    tests_run++;
    if (remaining !== COUNT_W'(eff)) begin tests_failed++; $display("FAIL load_remaining v=%0d: got %0d, expected %0d", v, remaining, eff); end
    for (int k = 1; k <= eff * 8 + 20; k++) begin
      tick();
      exp_expired = (k >= eff * 8 + 1);
      exp_rem     = exp_expired ? 4'd0 : COUNT_W'(eff - (k - 1) / 8);
      tests_run++;
      if (expired !== exp_expired) begin tests_failed++; $display("FAIL run_expired v=%0d k=%0d: got %b, expected %b", v, k, expired, exp_expired); end
      tests_run++;
      if (busy !== !exp_expired) begin tests_failed++; $display("FAIL run_busy v=%0d k=%0d: got %b, expected %b", v, k, busy, !exp_expired); end
      tests_run++;
      if (remaining !== exp_rem) begin tests_failed++; $display("FAIL run_remaining v=%0d k=%0d: got %0d, expected %0d", v, k, remaining, exp_rem); end
    end
    start_timer = 1'b0;
    tick();
    tests_run++;
    if (expired !== 1'b0) begin tests_failed++; $display("FAIL release_expired v=%0d: got %b, expected 0", v, expired); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL release_busy v=%0d: got %b, expected 0", v, busy); end
    tests_run++;
    if (remaining !== 4'd0) begin tests_failed++; $display("FAIL release_remaining v=%0d: got %0d, expected 0", v, remaining); end
  endtask

  // value=5, start dropped so edge L+drop_k samples 0 (17 coincides with a tick edge).
  task automatic test_abort(input int drop_k);
    logic [COUNT_W-1:0] exp_rem;
    value       = 4'd5;
    start_timer = 1'b1;
    tick();
    for (int k = 1; k < drop_k; k++) tick();
    exp_rem = COUNT_W'(5 - (drop_k - 2) / 8);
    tests_run++;
    if (remaining !== exp_rem) begin tests_failed++; $display("FAIL abort_pre_remaining drop=%0d: got %0d, expected %0d", drop_k, remaining, exp_rem); end
    start_timer = 1'b0;
    tick();
    tests_run++;
    if (remaining !== 4'd0) begin tests_failed++; $display("FAIL abort_remaining drop=%0d: got %0d, expected 0", drop_k, remaining); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy drop=%0d: got %b, expected 0", drop_k, busy); end
    for (int k = 0; k < 12; k++) begin
      tests_run++;
      if (expired !== 1'b0) begin tests_failed++; $display("FAIL abort_expired drop=%0d k=%0d: got %b, expected 0", drop_k, k, expired); end
      tick();
    end
  endtask

  task automatic test_reset_mid_run();
    value       = 4'd3;
    start_timer = 1'b1;
    tick();
    for (int k = 1; k <= 10; k++) tick();
    tests_run++;
    if (remaining !== 4'd2) begin tests_failed++; $display("FAIL midrun_remaining: got %0d, expected 2", remaining); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({one_hz_enable, two_hz_enable, expired, busy} !== 4'b0000) begin tests_failed++; $display("FAIL midrun_reset_flags: got %b, expected 0000", {one_hz_enable, two_hz_enable, expired, busy}); end
    tests_run++;
    if (remaining !== 4'd0) begin tests_failed++; $display("FAIL midrun_reset_remaining: got %0d, expected 0", remaining); end
    start_timer = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      tests_run++;
      if ({expired, busy} !== 2'b00) begin tests_failed++; $display("FAIL post_reset_idle k=%0d: got %b, expected 00", k, {expired, busy}); end
    end
  endtask

  task automatic test_back_to_back();
    test_countdown(1);
    test_countdown(2);
  endtask

`ifdef TIMER_PAUSE_EN
  // value=2, pause sampled on edges L+4..L+23; expiry moves from L+17 to L+37.
  task automatic test_pause();
    value       = 4'd2;
    start_timer = 1'b1;
    pause       = 1'b0;
    tick();
    for (int k = 1; k <= 3; k++) tick();
    pause = 1'b1;
    for (int k = 4; k <= 23; k++) begin
      tick();
      tests_run++;
      if ({one_hz_enable, two_hz_enable} !== 2'b00) begin tests_failed++; $display("FAIL pause_strobes k=%0d: got %b, expected 00", k, {one_hz_enable, two_hz_enable}); end
      tests_run++;
      if (remaining !== 4'd2) begin tests_failed++; $display("FAIL pause_remaining k=%0d: got %0d, expected 2", k, remaining); end
    end
    pause = 1'b0;
    for (int k = 24; k <= 40; k++) begin
      tick();
      tests_run++;
      if (expired !== (k >= 37)) begin tests_failed++; $display("FAIL pause_expired k=%0d: got %b, expected %b", k, expired, (k >= 37)); end
    end
    start_timer = 1'b0;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_strobes();
    test_countdown(3);
    test_countdown(0);
    test_abort(12);
    test_abort(17);
    test_reset_mid_run();
    test_back_to_back();
`ifdef TIMER_PAUSE_EN
    test_pause();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
